// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode
// (standard registered read or first-word-fall-through). Any depth >= 2.
module sync_fifo_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = 3,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         write_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         read_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_ok, rd_ok;

  // Status flags are plain decodes of the registered occupancy.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept decisions, pointer wrap, occupancy and sticky error next-state.
  always_comb begin
    wr_ok       = write_en & (~full | read_en);
    rd_ok       = read_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | (write_en & full & ~read_en);
    underflow_d = underflow_q | (read_en & empty);
    count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly from storage whenever the FIFO holds data.
      assign data_out = mem_q[rd_ptr_q];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] data_out_q;
      logic             rd_valid_q;

      // Registered read: capture the head word on each accepted pop.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out_q <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) begin
            data_out_q <= mem_q[rd_ptr_q];
          end
        end
      end

      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: three instances (depth 4 standard, depth 5
// standard, depth 4 FWFT) share one stimulus stream and are each compared
// every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_in;

  logic [7:0] dout [3];
  logic       rv   [3];
  logic       fl   [3];
  logic       em   [3];
  logic       af   [3];
  logic       ae   [3];
  logic       ov   [3];
  logic       un   [3];
  logic [2:0] cnt  [3];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [7:0]  mq [3][$];
  logic        m_ov   [3];
  logic        m_un   [3];
  logic        m_rv   [3];
  logic [7:0]  m_dout [3];
  int unsigned m_depth [3] = '{4, 5, 4};
  bit          m_fwft  [3] = '{1'b0, 1'b0, 1'b1};
  string       m_name  [3] = '{"d4", "d5", "fw"};

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_d4 (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(dout[0]), .rd_valid(rv[0]), .full(fl[0]), .empty(em[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]),
    .overflow(ov[0]), .underflow(un[0])
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(dout[1]), .rd_valid(rv[1]), .full(fl[1]), .empty(em[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]),
    .overflow(ov[1]), .underflow(un[1])
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(dout[2]), .rd_valid(rv[2]), .full(fl[2]), .empty(em[2]),
    .almost_full(af[2]), .almost_empty(ae[2]), .count(cnt[2]),
    .overflow(ov[2]), .underflow(un[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance every model by one clock edge using the current inputs.
  task automatic model_step(input logic r, input logic we, input logic [7:0] d, input logic re);
    for (int k = 0; k < 3; k++) begin
      int unsigned sz;
      bit          is_full, wr, rd;
      logic [7:0]  pv;
      sz = mq[k].size();
      if (r) begin
        mq[k].delete();
        m_ov[k]   = 1'b0;
        m_un[k]   = 1'b0;
        m_rv[k]   = 1'b0;
        m_dout[k] = 8'h00;
      end else begin
        is_full = (sz == m_depth[k]);
        wr = we && (!is_full || re);
        rd = re && (sz != 0);
        if (we && is_full && !re) m_ov[k] = 1'b1;
        if (re && sz == 0)        m_un[k] = 1'b1;
        m_rv[k] = rd;
        if (rd) begin
          pv = mq[k].pop_front();
          if (!m_fwft[k]) m_dout[k] = pv;
        end
        if (wr) mq[k].push_back(d);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int unsigned sz;
      sz = mq[k].size();
      check_eq({m_name[k], ".count"},     32'(cnt[k]), sz);
      check_eq({m_name[k], ".full"},      32'(fl[k]),  32'(sz == m_depth[k]));
      check_eq({m_name[k], ".empty"},     32'(em[k]),  32'(sz == 0));
      check_eq({m_name[k], ".almost_full"},  32'(af[k]), 32'(sz >= 3));
      check_eq({m_name[k], ".almost_empty"}, 32'(ae[k]), 32'(sz <= 1));
      check_eq({m_name[k], ".overflow"},  32'(ov[k]),  32'(m_ov[k]));
      check_eq({m_name[k], ".underflow"}, 32'(un[k]),  32'(m_un[k]));
      if (m_fwft[k]) begin
        check_eq({m_name[k], ".rd_valid"}, 32'(rv[k]), 32'(sz != 0));
        if (sz != 0) check_eq({m_name[k], ".data_out"}, 32'(dout[k]), 32'(mq[k][0]));
      end else begin
        check_eq({m_name[k], ".rd_valid"}, 32'(rv[k]),   32'(m_rv[k]));
        check_eq({m_name[k], ".data_out"}, 32'(dout[k]), 32'(m_dout[k]));
      end
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [7:0] d, input logic re);
    rst      = r;
    write_en = we;
    data_in  = d;
    read_en  = re;
    model_step(r, we, d, re);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int unsigned wp;
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00;

    step(1'b1, 1'b0, 8'h00, 1'b0);
    // Fill to full, flags ramp through thresholds
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b1, 8'h44, 1'b0);
    // Write while full: dropped on depth-4 instances
    step(1'b0, 1'b1, 8'h55, 1'b0);
    // Simultaneous read+write while full
    step(1'b0, 1'b1, 8'h66, 1'b1);
    // Drain past empty into underflow
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    // Read+write while empty: only the write lands
    step(1'b0, 1'b1, 8'h77, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // FWFT head appears without a read
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // Reset with three words stored
    step(1'b0, 1'b1, 8'hB6, 1'b0);
    step(1'b0, 1'b1, 8'hC7, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // Streaming with interleaved reads, exercises pointer wrap
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(8'h80 + i), (i % 3) != 0);
    for (int i = 0; i < 8; i++)  step(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized phases alternating fill-biased and drain-biased traffic
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 50) % 2 != 0) ? 80 : 30;
      step($urandom_range(99) == 0,
           $urandom_range(99) < wp,
           8'($urandom),
           $urandom_range(99) < (100 - wp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
